// File: rtl/cmp_arbiter.sv
// Round-robin arbiter that shares one registered unsigned magnitude comparator among N_REQ requesters.
// Optional per-requester grant statistics are enabled with `define CMP_ARB_STATS_EN.
module cmp_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 16,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_in,
  input  logic [N_REQ*W-1:0] b_in,
`ifdef CMP_ARB_STATS_EN
  input  logic [ID_W-1:0]    stat_sel,
  input  logic               stat_clr,
  output logic [15:0]        stat_cnt,
`endif
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               res_valid,
  output logic [ID_W-1:0]    res_id,
  output logic               res_equal,
  output logic               res_lower,
  output logic               res_greater
);

  logic [N_REQ-1:0] gnt_r;
  logic [ID_W-1:0]  ptr_r;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [ID_W-1:0]  id_r;
  logic             busy_r;
  logic             res_valid_r;
  logic [ID_W-1:0]  res_id_r;
  logic             res_equal_r;
  logic             res_lower_r;
  logic             res_greater_r;

  logic [N_REQ-1:0] elig_s;
  logic             sel_found_s;
  logic [ID_W-1:0]  sel_id_s;
  logic [ID_W:0]    sum_s;
  logic [ID_W-1:0]  idx_s;
  logic             hit_s;

  // Round-robin search starting just after the last granted index; the granted requester is masked.
  always_comb begin
    elig_s      = en ? (req & ~gnt_r) : {N_REQ{1'b0}};
    sel_found_s = 1'b0;
    sel_id_s    = {ID_W{1'b0}};
    sum_s       = {(ID_W+1){1'b0}};
    idx_s       = {ID_W{1'b0}};
    hit_s       = 1'b0;
    for (int j = 1; j <= N_REQ; j++) begin
      sum_s       = {1'b0, ptr_r} + (ID_W+1)'(j);
      sum_s       = (sum_s >= (ID_W+1)'(N_REQ)) ? (sum_s - (ID_W+1)'(N_REQ)) : sum_s;
      idx_s       = sum_s[ID_W-1:0];
      hit_s       = !sel_found_s && elig_s[idx_s];
      sel_id_s    = hit_s ? idx_s : sel_id_s;
      sel_found_s = sel_found_s | hit_s;
    end
  end

  // Grant stage latches the winner's operands; compare stage registers the result one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r         <= {N_REQ{1'b0}};
      ptr_r         <= ID_W'(N_REQ-1);
      a_r           <= {W{1'b0}};
      b_r           <= {W{1'b0}};
      id_r          <= {ID_W{1'b0}};
      busy_r        <= 1'b0;
      res_valid_r   <= 1'b0;
      res_id_r      <= {ID_W{1'b0}};
      res_equal_r   <= 1'b0;
      res_lower_r   <= 1'b0;
      res_greater_r <= 1'b0;
    end else begin
      gnt_r       <= sel_found_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << sel_id_s) : {N_REQ{1'b0}};
      res_valid_r <= |gnt_r;
      // busy mirrors the next-cycle value of |gnt | res_valid so it stays a plain register
      busy_r      <= sel_found_s | (|gnt_r);
      if (sel_found_s) begin
        ptr_r <= sel_id_s;
        a_r   <= a_in[sel_id_s*W +: W];
        b_r   <= b_in[sel_id_s*W +: W];
        id_r  <= sel_id_s;
      end else begin
        ptr_r <= ptr_r;
      end
      if (|gnt_r) begin
        res_id_r      <= id_r;
        res_equal_r   <= (a_r == b_r);
        res_lower_r   <= (a_r < b_r);
        res_greater_r <= (a_r > b_r);
      end else begin
        res_id_r <= res_id_r;
      end
    end
  end

  assign gnt         = gnt_r;
  assign busy        = busy_r;
  assign res_valid   = res_valid_r;
  assign res_id      = res_id_r;
  assign res_equal   = res_equal_r;
  assign res_lower   = res_lower_r;
  assign res_greater = res_greater_r;

`ifdef CMP_ARB_STATS_EN
  logic [15:0] cnt_r [N_REQ];
  logic [15:0] stat_cnt_r;

  // Saturating grant counters; clear takes priority over a same-edge increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) cnt_r[i] <= 16'h0000;
      stat_cnt_r <= 16'h0000;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (stat_clr) begin
          cnt_r[i] <= 16'h0000;
        end else if (sel_found_s && (int'(sel_id_s) == i) && (cnt_r[i] != 16'hFFFF)) begin
          cnt_r[i] <= cnt_r[i] + 16'h0001;
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
      stat_cnt_r <= (int'(stat_sel) < N_REQ) ? cnt_r[stat_sel] : 16'h0000;
    end
  end

  assign stat_cnt = stat_cnt_r;
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed self-checking bench for cmp_arbiter with hand-computed expected values.
module tb_cmp_arbiter;
  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  req;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic [3:0]  gnt;
  logic        busy;
  logic        res_valid;
  logic [1:0]  res_id;
  logic        res_equal;
  logic        res_lower;
  logic        res_greater;
`ifdef CMP_ARB_STATS_EN
  logic [1:0]  stat_sel;
  logic        stat_clr;
  logic [15:0] stat_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  cmp_arbiter #(.N_REQ(4), .W(16), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .a_in(a_in), .b_in(b_in),
`ifdef CMP_ARB_STATS_EN
    .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(stat_cnt),
`endif
    .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_id(res_id),
    .res_equal(res_equal), .res_lower(res_lower), .res_greater(res_greater)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    a_in[i*16 +: 16] = a;
    b_in[i*16 +: 16] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // {greater, equal, lower} for requester i with A=i, B=2
  logic [2:0] rr_flags [4];

  initial begin
    rr_flags[0] = 3'b001; rr_flags[1] = 3'b001; rr_flags[2] = 3'b010; rr_flags[3] = 3'b100;
    rst_n = 1'b0; en = 1'b1; req = 4'b0000; a_in = 64'h0; b_in = 64'h0;
`ifdef CMP_ARB_STATS_EN
    stat_sel = 2'd0; stat_clr = 1'b0;
`endif
    do_reset();
    check("rst_gnt", {28'h0, gnt}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_valid", {31'h0, res_valid}, 32'h0);
    check("rst_id_flags", {27'h0, res_id, res_greater, res_equal, res_lower}, 32'h0);

    // single request
    set_op(0, 16'h0010, 16'h0020);
    req = 4'b0001;
    step();
    check("single_gnt", {28'h0, gnt}, 32'h1);
    check("single_busy", {31'h0, busy}, 32'h1);
    req = 4'b0000;
    step();
    check("single_valid", {31'h0, res_valid}, 32'h1);
    check("single_id", {30'h0, res_id}, 32'h0);
    check("single_flags", {29'h0, res_greater, res_equal, res_lower}, 32'h1);
    check("single_gnt_off", {28'h0, gnt}, 32'h0);
    step();
    check("single_valid_off", {31'h0, res_valid}, 32'h0);
    check("single_busy_off", {31'h0, busy}, 32'h0);
    check("single_flags_hold", {29'h0, res_greater, res_equal, res_lower}, 32'h1);

    // round-robin fairness from a fresh pointer
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 16'(i), 16'h0002);
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_gnt", {28'h0, gnt}, 32'h1 << (k % 4));
      if (k > 0) begin
        check("rr_valid", {31'h0, res_valid}, 32'h1);
        check("rr_id", {30'h0, res_id}, 32'((k - 1) % 4));
        check("rr_flags", {29'h0, res_greater, res_equal, res_lower}, {29'h0, rr_flags[(k - 1) % 4]});
      end
    end
    req = 4'b0000;
    step();
    check("rr_last_id", {30'h0, res_id}, 32'h3);
    step();

    // masking, back-to-back grants to one requester, unsigned boundaries
    set_op(2, 16'hFFFF, 16'hFFFF);
    req = 4'b0100;
    step();
    check("mask_gnt1", {28'h0, gnt}, 32'h4);
    set_op(2, 16'hFFFF, 16'h0000);
    step();
    check("mask_gap", {28'h0, gnt}, 32'h0);
    check("mask_valid1", {31'h0, res_valid}, 32'h1);
    check("mask_id1", {30'h0, res_id}, 32'h2);
    check("max_equal", {29'h0, res_greater, res_equal, res_lower}, 32'h2);
    step();
    check("mask_gnt2", {28'h0, gnt}, 32'h4);
    check("mask_valid_gap", {31'h0, res_valid}, 32'h0);
    check("mask_busy", {31'h0, busy}, 32'h1);
    req = 4'b0000;
    step();
    check("max_greater", {29'h0, res_greater, res_equal, res_lower}, 32'h4);
    check("mask_id2", {30'h0, res_id}, 32'h2);
    step();

    // enable drop during grant cycle
    set_op(1, 16'h0005, 16'h0005);
    req = 4'b0010;
    step();
    check("en_gnt", {28'h0, gnt}, 32'h2);
    en = 1'b0;
    step();
    check("en_valid", {31'h0, res_valid}, 32'h1);
    check("en_id", {30'h0, res_id}, 32'h1);
    check("en_flags", {29'h0, res_greater, res_equal, res_lower}, 32'h2);
    check("en_no_gnt", {28'h0, gnt}, 32'h0);
    step();
    check("en_no_gnt2", {28'h0, gnt}, 32'h0);
    check("en_idle_busy", {31'h0, busy}, 32'h0);
    en = 1'b1;
    req = 4'b0000;
    step();

    // reset in the grant cycle drops the in-flight result
    set_op(3, 16'h0001, 16'h0009);
    req = 4'b1000;
    step();
    check("rst_mid_gnt", {28'h0, gnt}, 32'h8);
    rst_n = 1'b0;
    #1;
    check("rst_mid_clear", {26'h0, gnt, busy, res_valid}, 32'h0);
    req = 4'b0000;
    step();
    rst_n = 1'b1;
    step();
    check("rst_mid_valid", {31'h0, res_valid}, 32'h0);
    check("rst_mid_outs", {23'h0, gnt, busy, res_id, res_greater, res_equal, res_lower}, 32'h0);

`ifdef CMP_ARB_STATS_EN
    req = 4'b0010;
    for (int k = 0; k < 6; k++) step();
    req = 4'b0000;
    stat_sel = 2'd1;
    step();
    step();
    check("stat_three", {16'h0, stat_cnt}, 32'h3);
    stat_sel = 2'd0;
    step();
    check("stat_other", {16'h0, stat_cnt}, 32'h0);
    stat_sel = 2'd1;
    req = 4'b0010;
    stat_clr = 1'b1;
    step();
    check("stat_clr_gnt", {28'h0, gnt}, 32'h2);
    stat_clr = 1'b0;
    req = 4'b0000;
    step();
    check("stat_clr", {16'h0, stat_cnt}, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
